// File: rtl/run_monitor.sv
// Run monitor: watches retired PCs and stores to decide when a test program ends.
// A run ends on a tohost store, a tight halt loop, or a cycle timeout.
module run_monitor #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4000,
    parameter int unsigned HALT_REPEAT    = 8,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        state,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [DATA_W-1:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  retire_count,
    output logic [DATA_W-1:0] signature
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StRun     = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;
    localparam logic [1:0] StTimeout = 2'd3;

    // The repeat counter never needs to exceed HALT_REPEAT-1: the run ends there.
    localparam int unsigned REP_W = (HALT_REPEAT > 2) ? $clog2(HALT_REPEAT) : 1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic [DATA_W-1:0] sig_q, sig_d;
    logic [DATA_W-1:0] exit_q, exit_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;

    logic              same_pc;
    logic              tohost_hit;
    logic              halt_hit;
    logic              timeout_hit;
    logic [DATA_W-1:0] addr_ext;

    always_comb begin
        addr_ext    = DATA_W'(mem_addr);
        same_pc     = pc_valid && (pc_in == last_pc_q);
        tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
        halt_hit    = same_pc && (rep_q == REP_W'(HALT_REPEAT - 2));
        timeout_hit = (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));

        state_d   = state_q;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        sig_d     = sig_q;
        exit_d    = exit_q;
        last_pc_d = last_pc_q;
        rep_d     = rep_q;
        pass_d    = pass_q;
        fail_d    = fail_q;

        if (start) begin
            // The start cycle itself is not a RUN cycle; retire/store inputs are dropped.
            state_d   = StRun;
            cycle_d   = '0;
            retire_d  = '0;
            sig_d     = '0;
            exit_d    = '0;
            last_pc_d = '0;
            rep_d     = '0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
        end else if (state_q == StRun) begin
            if (cycle_q != '1) begin
                cycle_d = cycle_q + CNT_W'(1);
            end
            if (pc_valid && (retire_q != '1)) begin
                retire_d = retire_q + CNT_W'(1);
            end

            if (same_pc) begin
                rep_d = rep_q + REP_W'(1);
            end else if (pc_valid) begin
                rep_d     = '0;
                last_pc_d = pc_in;
            end

            if (mem_we && !tohost_hit) begin
                sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ mem_wdata ^ addr_ext;
            end

            // End events in priority order: tohost, halt loop, timeout.
            if (tohost_hit) begin
                state_d = StDone;
                exit_d  = mem_wdata;
                pass_d  = (mem_wdata == DATA_W'(1));
                fail_d  = (mem_wdata != DATA_W'(1));
            end else if (halt_hit) begin
                state_d = StDone;
                exit_d  = '0;
                pass_d  = 1'b1;
                fail_d  = 1'b0;
            end else if (timeout_hit) begin
                state_d = StTimeout;
                exit_d  = '1;
                pass_d  = 1'b0;
                fail_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cycle_q   <= '0;
            retire_q  <= '0;
            sig_q     <= '0;
            exit_q    <= '0;
            last_pc_q <= '0;
            rep_q     <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            retire_q  <= retire_d;
            sig_q     <= sig_d;
            exit_q    <= exit_d;
            last_pc_q <= last_pc_d;
            rep_q     <= rep_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
        end
    end

    // Both end states have bit 1 set, so done is a plain decode of the state register.
    assign state        = state_q;
    assign done         = state_q[1];
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign exit_code    = exit_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
    assign signature    = sig_q;

endmodule
